// File: rtl/axi_burst_arbiter.sv
// Arbitrates N read requesters onto one AXI read channel and runs one independent write channel.
// Define AXI_ARB_ROUND_ROBIN_EN for round-robin read arbitration; otherwise the lowest index wins.
module axi_burst_arbiter #(
    parameter int N_PORTS   = 2,
    parameter int MAX_LEN_W = 4
) (
    input  logic                          aclk,
    input  logic                          rst,
    input  logic [N_PORTS-1:0]            rd_req,
    input  logic [32*N_PORTS-1:0]         rd_addr,
    input  logic [MAX_LEN_W*N_PORTS-1:0]  rd_len,
    output logic [N_PORTS-1:0]            rd_valid,
    output logic [N_PORTS-1:0]            rd_last,
    output logic [31:0]                   rd_data,
    input  logic                          wr_req,
    input  logic [31:0]                   wr_addr,
    input  logic [MAX_LEN_W-1:0]          wr_len,
    input  logic [3:0]                    wr_sel,
    input  logic [31:0]                   wr_data,
    input  logic                          wr_dvalid,
    output logic                          wr_ready,
    output logic                          wr_done,
    output logic [3:0]                    arid,
    output logic [31:0]                   araddr,
    output logic [7:0]                    arlen,
    output logic [2:0]                    arsize,
    output logic [1:0]                    arburst,
    output logic                          arvalid,
    input  logic                          arready,
    input  logic [3:0]                    rid,
    input  logic [31:0]                   rdata,
    input  logic                          rlast,
    input  logic                          rvalid,
    output logic                          rready,
    output logic [3:0]                    awid,
    output logic [31:0]                   awaddr,
    output logic [7:0]                    awlen,
    output logic [2:0]                    awsize,
    output logic [1:0]                    awburst,
    output logic                          awvalid,
    input  logic                          awready,
    output logic [3:0]                    wid,
    output logic [31:0]                   wdata,
    output logic [3:0]                    wstrb,
    output logic                          wlast,
    output logic                          wvalid,
    input  logic                          wready,
    input  logic                          bvalid,
    output logic                          bready
);
    localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} r_state_e;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_ADDR = 2'd1, W_DATA = 2'd2, W_RESP = 2'd3} w_state_e;

    r_state_e             r_state_q, r_state_d;
    logic [IDX_W-1:0]     r_idx_q, r_idx_d, grant_s;
    logic [31:0]          r_addr_q, r_addr_d, sel_addr_s;
    logic [MAX_LEN_W-1:0] r_len_q, r_len_d, sel_len_s;
    logic [MAX_LEN_W-1:0] r_cnt_q, r_cnt_d;
    w_state_e             w_state_q, w_state_d;
    logic [31:0]          w_addr_q, w_addr_d;
    logic [MAX_LEN_W-1:0] w_len_q, w_len_d, w_cnt_q, w_cnt_d;
    logic [3:0]           w_sel_q, w_sel_d;
    logic                 unused_s;

`ifdef AXI_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             found_s;

    // Search starts at the pointer and wraps, so the last-served port goes to the back of the line.
    always_comb begin
        int cand;
        grant_s = '0;
        found_s = 1'b0;
        for (int k = 0; k < N_PORTS; k++) begin
            cand = (int'(rr_ptr_q) + k) % N_PORTS;
            if (!found_s && rd_req[cand[IDX_W-1:0]]) begin
                grant_s = cand[IDX_W-1:0];
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Pointer moves past the granted port only when its burst ends.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (r_state_q == R_DATA && rvalid && rlast) begin
            rr_ptr_d = (r_idx_q == IDX_W'(N_PORTS - 1)) ? IDX_W'(0) : r_idx_q + IDX_W'(1);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) rr_ptr_q <= '0;
        else     rr_ptr_q <= rr_ptr_d;
    end
`else
    // Fixed priority: lowest requesting index wins.
    always_comb begin
        grant_s = '0;
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            if (rd_req[i]) grant_s = IDX_W'(i);
            else           grant_s = grant_s;
        end
    end
`endif

    // Select the granted port's address and length.
    always_comb begin
        sel_addr_s = 32'h0;
        sel_len_s  = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (grant_s == IDX_W'(i)) begin
                sel_addr_s = rd_addr[32*i +: 32];
                sel_len_s  = rd_len[MAX_LEN_W*i +: MAX_LEN_W];
            end else begin
                sel_addr_s = sel_addr_s;
                sel_len_s  = sel_len_s;
            end
        end
    end

    // Read FSM state and burst context registers.
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            r_idx_q   <= '0;
            r_addr_q  <= 32'h0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            r_idx_q   <= r_idx_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
        end
    end

    // Read next state; rlast always ends the burst, even if the beat count disagrees.
    always_comb begin
        r_state_d = r_state_q;
        r_idx_d   = r_idx_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        case (r_state_q)
            R_IDLE: begin
                if (|rd_req) begin
                    r_state_d = R_ADDR;
                    r_idx_d   = grant_s;
                    r_addr_d  = sel_addr_s;
                    r_len_d   = sel_len_s;
                    r_cnt_d   = '0;
                end else begin
                    r_state_d = R_IDLE;
                end
            end
            R_ADDR: begin
                if (arready) r_state_d = R_DATA;
                else         r_state_d = R_ADDR;
            end
            R_DATA: begin
                if (rvalid) begin
                    r_cnt_d   = r_cnt_q + MAX_LEN_W'(1);
                    r_state_d = rlast ? R_IDLE : R_DATA;
                end else begin
                    r_state_d = R_DATA;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read channel outputs.
    always_comb begin
        arvalid  = 1'b0;
        rready   = 1'b0;
        rd_valid = '0;
        rd_last  = '0;
        case (r_state_q)
            R_ADDR: arvalid = 1'b1;
            R_DATA: begin
                rready            = 1'b1;
                rd_valid[r_idx_q] = rvalid;
                rd_last[r_idx_q]  = rvalid && rlast;
            end
            default: arvalid = 1'b0;
        endcase
    end

    assign araddr  = r_addr_q;
    assign arlen   = 8'(r_len_q);
    assign arid    = 4'(r_idx_q);
    assign arsize  = 3'h2;
    assign arburst = 2'h1;
    assign rd_data = rdata;
    assign unused_s = ^rid;

    // Write FSM state and burst context registers.
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            w_addr_q  <= 32'h0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_sel_q   <= 4'h0;
        end else begin
            w_state_q <= w_state_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_sel_q   <= w_sel_d;
        end
    end

    // Write next state.
    always_comb begin
        w_state_d = w_state_q;
        w_addr_d  = w_addr_q;
        w_len_d   = w_len_q;
        w_cnt_d   = w_cnt_q;
        w_sel_d   = w_sel_q;
        case (w_state_q)
            W_IDLE: begin
                if (wr_req) begin
                    w_state_d = W_ADDR;
                    w_addr_d  = wr_addr;
                    w_len_d   = wr_len;
                    w_sel_d   = wr_sel;
                    w_cnt_d   = '0;
                end else begin
                    w_state_d = W_IDLE;
                end
            end
            W_ADDR: begin
                if (awready) w_state_d = W_DATA;
                else         w_state_d = W_ADDR;
            end
            W_DATA: begin
                if (wr_dvalid && wready) begin
                    w_cnt_d   = w_cnt_q + MAX_LEN_W'(1);
                    w_state_d = (w_cnt_q == w_len_q) ? W_RESP : W_DATA;
                end else begin
                    w_state_d = W_DATA;
                end
            end
            W_RESP: begin
                if (bvalid) w_state_d = W_IDLE;
                else        w_state_d = W_RESP;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write channel outputs.
    always_comb begin
        awvalid  = 1'b0;
        wvalid   = 1'b0;
        wlast    = 1'b0;
        wr_ready = 1'b0;
        bready   = 1'b0;
        wr_done  = 1'b0;
        case (w_state_q)
            W_ADDR: awvalid = 1'b1;
            W_DATA: begin
                wvalid   = wr_dvalid;
                wr_ready = wready;
                wlast    = (w_cnt_q == w_len_q);
            end
            W_RESP: begin
                bready  = 1'b1;
                wr_done = bvalid;
            end
            default: awvalid = 1'b0;
        endcase
    end

    assign awaddr  = w_addr_q;
    assign awlen   = 8'(w_len_q);
    assign awid    = 4'h1;
    assign awsize  = 3'h2;
    assign awburst = 2'h1;
    assign wid     = 4'h1;
    assign wdata   = wr_data;
    assign wstrb   = w_sel_q;
endmodule

// File: doc/axi_burst_arbiter.md
AXI_BURST_ARBITER -- requirements
Module: axi_burst_arbiter

Interface
REQ-001 The block SHALL have parameter N_PORTS, default 2, giving the number of read requester ports (2..4).
REQ-002 The block SHALL have parameter MAX_LEN_W, default 4, giving the burst length field width; burst length is len+1 beats.
REQ-003 The block SHALL have these clock and reset ports; the design uses one clock, and reset is asynchronous and active-high:
- aclk  in  1  clock
- rst  in  1  asynchronous active-high reset
REQ-004 The block SHALL have these read requester ports:
- rd_req  in  N_PORTS  per-port read request
- rd_addr  in  32*N_PORTS  per-port start address, port i at bits [32i+31:32i]
- rd_len  in  MAX_LEN_W*N_PORTS  per-port beats-1
- rd_valid  out  N_PORTS  per-port beat valid
- rd_last  out  N_PORTS  per-port last beat
- rd_data  out  32  shared read data
REQ-005 The block SHALL have these write requester ports:
- wr_req  in  1  write request
- wr_addr  in  32  write start address
- wr_len  in  MAX_LEN_W  beats-1
- wr_sel  in  4  byte strobe
- wr_data  in  32  write data
- wr_dvalid  in  1  write data valid
- wr_ready  out  1  write beat accepted
- wr_done  out  1  one-cycle write response pulse
REQ-006 The block SHALL have these AXI master ports:
- arid/araddr/arlen/arsize/arburst/arvalid  out  4/32/8/3/2/1
- arready  in  1
- rid/rdata/rlast/rvalid  in  4/32/1/1
- rready  out  1
- awid/awaddr/awlen/awsize/awburst/awvalid  out  4/32/8/3/2/1
- awready  in  1
- wid/wdata/wstrb/wlast/wvalid  out  4/32/4/1/1
- wready  in  1
- bvalid  in  1
- bready  out  1

Function
REQ-007 Read FSM SHALL have states R_IDLE, R_ADDR, R_DATA; write FSM SHALL have states W_IDLE, W_ADDR, W_DATA, W_RESP; the two FSMs SHALL run independently.
REQ-008 In R_IDLE with any rd_req bit high, the FSM SHALL latch the granted port index, address and length, then go to R_ADDR on the next cycle.
REQ-009 In R_ADDR, arvalid SHALL be 1, with araddr/arlen equal to the latched values; arlen SHALL be zero-extended to 8 bits, arid = granted index, arsize = 3'h2, arburst = 2'h1; on arvalid&&arready the FSM SHALL go to R_DATA.
REQ-010 In R_DATA, rready SHALL be 1 and rd_valid[g] = rvalid (combinational), with rd_data = rdata; all other rd_valid bits SHALL be 0.
REQ-011 rd_last[g] SHALL be rvalid&&rlast; on that beat the FSM SHALL return to R_IDLE, giving a minimum 1 idle cycle between bursts.
REQ-012 The grant SHALL be held for the whole burst; changes on rd_req during a burst SHALL be ignored.
REQ-013 Requesters SHALL hold rd_req until their first rd_valid; the block SHALL deliver every beat even if rd_req falls mid-burst.
REQ-014 An internal beat counter SHALL count accepted beats; if rlast arrives with count != len, the block SHALL still terminate on rlast.
REQ-015 In W_IDLE with wr_req, the write FSM SHALL latch address, length and strobe, then go to W_ADDR.
REQ-016 In W_ADDR, awvalid SHALL be 1 and awid = 4'h1; on awready the FSM SHALL go to W_DATA.
REQ-017 In W_DATA, wvalid SHALL equal wr_dvalid, wr_ready SHALL equal wready, and wlast SHALL be 1 on beat number len (counted from 0).
REQ-018 The FSM SHALL go to W_RESP on wvalid&&wready&&wlast; bready SHALL be 1 in W_RESP, and bvalid SHALL pulse wr_done for 1 cycle and return to W_IDLE.
REQ-019 Simultaneous read and write requests SHALL both start in the same cycle; no address-hazard check is made, and ordering is the requesters' duty.

Reset
REQ-020 On rst, both FSMs SHALL go to IDLE and counters SHALL clear, and the round-robin pointer SHALL reset to port 0.
REQ-021 While rst is high, every valid/ready/last/done output SHALL be 0.
REQ-022 Assertion of rst mid-burst SHALL abort the burst immediately, with no further beats forwarded.

Configuration
REQ-023 Macro AXI_ARB_ROUND_ROBIN_EN SHALL select the arbitration scheme. Defined: round-robin starting at the port after the last granted one, with the pointer updated at burst end. Undefined: fixed priority, lowest index wins.

Verification
REQ-024 Port0 rd_req, addr 0x1FC0_0000, len 3 -> araddr 0x1FC0_0000, arlen 8'h3, arid 0; four rd_valid[0] beats, rd_last[0] on beat 4.
REQ-025 Ports 0 and 1 request continuously -> with RR_EN, grants alternate 0,1,0; without it, port 0 is granted every burst.
REQ-026 wr_req addr 0x0000_0100, len 7, wready toggling -> 8 W beats, wlast on the 8th, one wr_done after bvalid.
REQ-027 Read len 15 and write len 0 issued in the same cycle -> arvalid and awvalid both rise the next cycle, and both complete.
REQ-028 rst asserted on beat 2 of a 4-beat read -> rready=0, rd_valid=0 in the same cycle; a new request after release proceeds normally.
REQ-029 rlast on beat 2 with len 3 -> rd_last asserted on beat 2, and the FSM returns to R_IDLE.
